// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronizes pbRaw and qualifies each level change with a stability counter.
// Optional macro PB_GLITCH_COUNT_EN adds the saturating glitchCnt output (rejected-bounce count).
module pb_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pbRaw,
  output logic       clkPB,
  output logic       busy
`ifdef PB_GLITCH_COUNT_EN
  ,
  output logic [7:0] glitchCnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pb_sync;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clk_pb_q, clk_pb_d;
  logic                   busy_q, busy_d;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pbRaw};
  assign pb_sync = sync_q[SYNC_STAGES-1];

  // Next state: a reversal in a WAIT state falls back to the stable state it left.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOW: begin
        cnt_d = '0;
        if (pb_sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        if (!pb_sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HIGH: begin
        cnt_d = '0;
        if (!pb_sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (pb_sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
    clk_pb_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
    busy_d   = (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
  end

  // Outputs are registered copies of the next-state decode, so they track the state register exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      state_q  <= S_LOW;
      cnt_q    <= '0;
      clk_pb_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_pb_q <= clk_pb_d;
      busy_q   <= busy_d;
    end
  end

  assign clkPB = clk_pb_q;
  assign busy  = busy_q;

`ifdef PB_GLITCH_COUNT_EN
  logic [7:0] glitch_q, glitch_d;
  logic       abort_c;

  // Saturating count of qualifications aborted by a reversal.
  always_comb begin
    abort_c  = ((state_q == S_WAIT_HIGH) && !pb_sync) ||
               ((state_q == S_WAIT_LOW)  &&  pb_sync);
    glitch_d = glitch_q;
    if (abort_c && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitchCnt = glitch_q;
`endif

endmodule

// File: tb/tb_pb_debouncer.sv
// Self-checking bench for pb_debouncer (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock).
module tb_pb_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  logic pbRaw = 1'b0;
  logic clkPB;
  logic busy;
`ifdef PB_GLITCH_COUNT_EN
  logic [7:0] glitchCnt;
`endif

  int checks   = 0;
  int failures = 0;

  pb_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pbRaw(pbRaw),
    .clkPB(clkPB),
    .busy(busy)
`ifdef PB_GLITCH_COUNT_EN
    ,
    .glitchCnt(glitchCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FSM sees pbRaw delayed by S edges; the clean level flips once D
  // consecutive samples disagree with it, and an agreeing sample ends any partial run.
  bit m_level  = 1'b0;
  bit m_busy   = 1'b0;
  int m_glitch = 0;
  int m_run    = 0;
  bit raw_q[$];

  task automatic model_clear();
    m_level  = 1'b0;
    m_busy   = 1'b0;
    m_glitch = 0;
    m_run    = 0;
    raw_q.delete();
    for (int i = 0; i < S; i++) raw_q.push_back(1'b0);
  endtask

  initial begin
    bit s;
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_clear();
      end else begin
        s = raw_q.pop_front();
        raw_q.push_back(pbRaw);
        if (s == m_level) begin
          if (m_run > 0 && m_glitch < 255) m_glitch++;
          m_run = 0;
        end else begin
          m_run++;
          if (m_run >= D) begin
            m_level = ~m_level;
            m_run   = 0;
          end
        end
        m_busy = (m_run > 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("clkPB_vs_model", 8'(clkPB), 8'(m_level));
      check("busy_vs_model", 8'(busy), 8'(m_busy));
`ifdef PB_GLITCH_COUNT_EN
      check("glitchCnt_vs_model", glitchCnt, 8'(m_glitch));
`endif
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_glitch(input string name, input int exp);
`ifdef PB_GLITCH_COUNT_EN
    check(name, glitchCnt, 8'(exp));
`endif
  endtask

  initial begin
    bit saw_high;
    // 1. Reset with pbRaw high, then requalify after release
    reset = 1'b0;
    pbRaw = 1'b1;
    #2;
    check("rst_clkPB", 8'(clkPB), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check_glitch("rst_glitch", 0);
    #8 reset = 1'b1;
    edges(5);
    check("rst_rel_e5_clkPB", 8'(clkPB), 8'd0);
    edges(1);
    check("rst_rel_e6_clkPB", 8'(clkPB), 8'd1);

    // Release from high
    @(negedge clk) pbRaw = 1'b0;
    edges(3);
    check("rel_e3_busy", 8'(busy), 8'd1);
    edges(2);
    check("rel_e5_clkPB", 8'(clkPB), 8'd1);
    edges(1);
    check("rel_e6_clkPB", 8'(clkPB), 8'd0);
    check("rel_e6_busy", 8'(busy), 8'd0);

    // 2. Clean press
    @(negedge clk) pbRaw = 1'b1;
    edges(2);
    check("press_e2_busy", 8'(busy), 8'd0);
    edges(1);
    check("press_e3_busy", 8'(busy), 8'd1);
    edges(2);
    check("press_e5_clkPB", 8'(clkPB), 8'd0);
    edges(1);
    check("press_e6_clkPB", 8'(clkPB), 8'd1);
    check("press_e6_busy", 8'(busy), 8'd0);
    @(negedge clk) pbRaw = 1'b0;
    edges(10);

    // 3. Two-cycle glitch
    @(negedge clk) pbRaw = 1'b1;
    @(negedge clk);
    @(negedge clk) pbRaw = 1'b0;
    edges(1);
    check("glitch_e3_busy", 8'(busy), 8'd1);
    edges(1);
    check("glitch_e4_busy", 8'(busy), 8'd1);
    edges(1);
    check("glitch_e5_busy", 8'(busy), 8'd0);
    check("glitch_e5_clkPB", 8'(clkPB), 8'd0);
    check_glitch("glitch_cnt1", 1);
    edges(5);

    // 4. Bounce 1,0,1,0 then hold 1
    @(negedge clk) pbRaw = 1'b1;
    @(negedge clk) pbRaw = 1'b0;
    @(negedge clk) pbRaw = 1'b1;
    @(negedge clk) pbRaw = 1'b0;
    @(negedge clk) pbRaw = 1'b1;
    edges(5);
    check("bounce_e5_clkPB", 8'(clkPB), 8'd0);
    edges(1);
    check("bounce_e6_clkPB", 8'(clkPB), 8'd1);
    check_glitch("bounce_cnt3", 3);

    // 5. Threshold: 4-cycle pulse accepted, 3-cycle pulse rejected
    @(negedge clk) pbRaw = 1'b0;
    edges(12);
    @(negedge clk) pbRaw = 1'b1;
    repeat (4) @(negedge clk);
    pbRaw = 1'b0;
    edges(2);
    check("thr4_clkPB", 8'(clkPB), 8'd1);
    edges(10);
    check("thr4_fall_clkPB", 8'(clkPB), 8'd0);
    @(negedge clk) pbRaw = 1'b1;
    repeat (3) @(negedge clk);
    pbRaw = 1'b0;
    saw_high = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      saw_high |= clkPB;
    end
    check("thr3_no_rise", 8'(saw_high), 8'd0);
    check_glitch("thr3_cnt4", 4);

    // 6. Reset during S_WAIT_HIGH, then requalify with pbRaw still high
    @(negedge clk) pbRaw = 1'b1;
    edges(3);
    check("mid_wh_busy", 8'(busy), 8'd1);
    reset = 1'b0;
    #1;
    check("mid_wh_rst_busy", 8'(busy), 8'd0);
    check("mid_wh_rst_clkPB", 8'(clkPB), 8'd0);
    check_glitch("mid_wh_rst_glitch", 0);
    edges(2);
    @(negedge clk) reset = 1'b1;
    edges(5);
    check("mid_rel_e5_clkPB", 8'(clkPB), 8'd0);
    edges(1);
    check("mid_rel_e6_clkPB", 8'(clkPB), 8'd1);

    // Reset during S_WAIT_LOW clears a high clkPB at once
    @(negedge clk) pbRaw = 1'b0;
    edges(3);
    check("mid_wl_clkPB", 8'(clkPB), 8'd1);
    check("mid_wl_busy", 8'(busy), 8'd1);
    reset = 1'b0;
    #1;
    check("mid_wl_rst_clkPB", 8'(clkPB), 8'd0);
    check("mid_wl_rst_busy", 8'(busy), 8'd0);
    edges(2);
    @(negedge clk) reset = 1'b1;
    edges(8);
    check("final_clkPB", 8'(clkPB), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
